mdu_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the EX stage.
- It executes mult, multu, div, divu, mthi and mtlo.
- The EX stage issues a request with a start strobe and stalls on busy. Retirement logic reads hi/lo for mfhi and mflo.
- Multiply uses shift-add and divide uses restoring division, one bit per cycle.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_if.sv | 24 ++
 rtl/mdu_sign_fix.sv | 11 +
 rtl/mdu_unit.sv | 134 +++++++++++++
 tb/tb_mdu_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and small op-classification helpers.
package mdu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_arith(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage (master) and the MDU (slave).
interface mdu_if #(
  parameter int WIDTH = mdu_pkg::WIDTH
);
  logic [2:0]       mduOp;
  logic             start;
  logic             cancel;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mduOp, start, cancel, din1, din2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  mduOp, start, cancel, din1, din2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; serves both as abs() on operands
// and as sign restoration on results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = neg ? (~a + 1'b1) : a;
endmodule

// File: rtl/mdu_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// One result bit per cycle; sign handled by abs on entry and negate on exit.
module mdu_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mdu_op_e          op;
  mdu_state_e       state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_reg, mq_reg, opnd_reg;
  logic             div_reg, neg_lo_reg, neg_hi_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg;
  logic             accept, finish, load_mt;

  logic             sgn, dv, fix_ok, neg1, neg2;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign op  = mdu_op_e'(bus.mduOp);
  assign sgn = is_signed(op);
  assign dv  = is_div(op);
  // A zero divisor leaves the dividend untouched so HI returns it verbatim.
  assign fix_ok = !(dv && (bus.din2 == '0));
  assign neg1   = sgn && bus.din1[WIDTH-1] && fix_ok;
  assign neg2   = sgn && bus.din2[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_abs1 (.neg(neg1), .a(bus.din1), .y(abs1));
  mdu_sign_fix #(.W(WIDTH)) u_abs2 (.neg(neg2), .a(bus.din2), .y(abs2));

  assign mul_sum  = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, opnd_reg} : '0);
  assign div_sh   = {acc_reg, mq_reg[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd_reg});
  assign div_diff = div_sh - {1'b0, opnd_reg};

  mdu_sign_fix #(.W(2*WIDTH)) u_prod (.neg(neg_lo_reg && !div_reg), .a({acc_reg, mq_reg}), .y(prod_fix));
  mdu_sign_fix #(.W(WIDTH))   u_quot (.neg(neg_lo_reg && div_reg),  .a(mq_reg),            .y(quot_fix));
  mdu_sign_fix #(.W(WIDTH))   u_rem  (.neg(neg_hi_reg),             .a(acc_reg),           .y(rem_fix));

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.cancel && is_arith(op)) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.cancel)
          state_next = IDLE;
        else if (count_reg == LAST)
          state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        finish     = !bus.cancel;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_mt = (state_reg == IDLE) && bus.start && !bus.cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      mq_reg     <= '0;
      opnd_reg   <= '0;
      div_reg    <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= finish;
      if (accept) begin
        // Multiply keeps the multiplier in mq; divide keeps the dividend there.
        mq_reg     <= dv ? abs1 : abs2;
        opnd_reg   <= dv ? abs2 : abs1;
        acc_reg    <= '0;
        count_reg  <= '0;
        div_reg    <= dv;
        neg_lo_reg <= sgn && (bus.din1[WIDTH-1] ^ bus.din2[WIDTH-1]) && fix_ok;
        neg_hi_reg <= sgn && dv && bus.din1[WIDTH-1] && fix_ok;
      end else if (state_reg == RUN && !bus.cancel) begin
        count_reg <= count_reg + 1'b1;
        if (div_reg) begin
          acc_reg <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
          mq_reg  <= {mq_reg[WIDTH-2:0], div_ge};
        end else begin
          acc_reg <= mul_sum[WIDTH:1];
          mq_reg  <= {mul_sum[0], mq_reg[WIDTH-1:1]};
        end
      end
      if (finish) begin
        if (div_reg) begin
          hi_reg <= rem_fix;
          lo_reg <= quot_fix;
        end else begin
          hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
          lo_reg <= prod_fix[WIDTH-1:0];
        end
      end else if (load_mt) begin
        if (op == MDU_MTHI) hi_reg <= bus.din1;
        if (op == MDU_MTLO) lo_reg <= bus.din1;
      end
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized scoreboard bench for mdu_unit: expected {hi,lo} queued at issue,
// compared by a monitor whenever done pulses.
module tb_mdu_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mdu_if #(.WIDTH(32)) bus();

  mdu_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {63'b0, bus.done}, 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        $display("result hi=%h lo=%h (expect hi=%h lo=%h)", bus.hi, bus.lo, exp_v[63:32], exp_v[31:0]);
        check("result_hi", {32'b0, bus.hi}, {32'b0, exp_v[63:32]});
        check("result_lo", {32'b0, bus.lo}, {32'b0, exp_v[31:0]});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.mduOp  = 3'd0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", {63'b0, bus.busy}, 64'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    wait_idle();
    bus.mduOp = op;
    bus.din1  = a;
    bus.din2  = b;
    bus.start = 1'b1;
    if (push && op inside {[3'd1:3'd4]}) exp_q.push_back(model(op, a, b));
    $display("issue op=%0d din1=%h din2=%h", op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mduOp = 3'd0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int busy_cycles);
    issue(op, a, b, 1'b1);
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
    if (busy_cycles >= 100) check("busy_timeout", {63'b0, bus.busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  logic [2:0]  dop [8] = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2};
  logic [31:0] da  [8] = '{32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100,
                           32'h1234_5678, 32'h8000_0000, 32'hFFFF_FF00, 32'd0};
  logic [31:0] db  [8] = '{32'd3, 32'h8000_0000, 32'd2, 32'd7,
                           32'd0, 32'hFFFF_FFFF, 32'd0, 32'hDEAD_BEEF};

  initial begin
    int bc, d0;
    logic [31:0] a, b, v, hold_hi, hold_lo;
    logic [2:0] op;

    drive_idle();
    bus.din1 = '0;
    bus.din2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_hi", {32'b0, bus.hi}, 64'd0);
    check("reset_lo", {32'b0, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    d0 = done_cnt;
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    check("multu_busy_cycles", 64'(bc), 64'd33);
    check("multu_done_pulses", 64'(done_cnt - d0), 64'd1);

    for (int i = 0; i < 8; i++) run_op(dop[i], da[i], db[i], bc);

    // mthi then mtlo back to back, then a cancelled mthi
    d0 = done_cnt;
    bus.mduOp = 3'd5; bus.din1 = 32'hABCD_0000; bus.start = 1'b1;
    @(posedge clk); #1;
    check("mthi_hi", {32'b0, bus.hi}, {32'b0, 32'hABCD_0000});
    check("mthi_busy", {63'b0, bus.busy}, 64'd0);
    bus.mduOp = 3'd6; bus.din1 = 32'h0000_1234;
    @(posedge clk); #1;
    check("mtlo_lo", {32'b0, bus.lo}, {32'b0, 32'h0000_1234});
    check("mtlo_hi_kept", {32'b0, bus.hi}, {32'b0, 32'hABCD_0000});
    bus.mduOp = 3'd5; bus.din1 = 32'hDEAD_BEEF; bus.cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_mthi_hi", {32'b0, bus.hi}, {32'b0, 32'hABCD_0000});
    drive_idle();
    check("mt_no_done", 64'(done_cnt - d0), 64'd0);

    // second start while busy must be ignored
    d0 = done_cnt;
    issue(3'd2, 32'd7, 32'd9, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.mduOp = 3'd2; bus.din1 = 32'd3; bus.din2 = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    wait_idle();
    repeat (40) @(posedge clk);
    #1;
    check("busy_start_ignored", 64'(done_cnt - d0), 64'd1);

    // cancel mid-multiply
    hold_hi = bus.hi;
    hold_lo = bus.lo;
    d0 = done_cnt;
    issue(3'd2, 32'd5, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_busy", {63'b0, bus.busy}, 64'd0);
    bus.cancel = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("cancel_no_done", 64'(done_cnt - d0), 64'd0);
    check("cancel_hi", {32'b0, bus.hi}, {32'b0, hold_hi});
    check("cancel_lo", {32'b0, bus.lo}, {32'b0, hold_lo});

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        op = 3'($urandom_range(1, 4));
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: b = 32'hFFFF_FFFF;
          2: a = 32'h8000_0000;
          3: b = 32'($urandom_range(1, 15));
          default: ;
        endcase
        run_op(op, a, b, bc);
      end else begin
        op = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6;
        v = $urandom;
        bus.mduOp = op; bus.din1 = v; bus.start = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        $display("move op=%0d value=%h", op, v);
        if (op == 3'd5) check("rand_mthi", {32'b0, bus.hi}, {32'b0, v});
        else check("rand_mtlo", {32'b0, bus.lo}, {32'b0, v});
      end
    end

    // asynchronous reset mid-divide
    bus.mduOp = 3'd5; bus.din1 = 32'h55AA_55AA; bus.start = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    issue(3'd3, $urandom, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hi", {32'b0, bus.hi}, 64'd0);
    check("rst_lo", {32'b0, bus.lo}, 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
